// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the decode-stage hazard scoreboard:
// instruction field positions and the register-index / counter types.
package hazard_pkg;
    localparam int RS1_MSB = 19;
    localparam int RS1_LSB = 15;
    localparam int RS2_MSB = 14;
    localparam int RS2_LSB = 10;
    localparam int RD_MSB  = 24;
    localparam int RD_LSB  = 20;

    typedef logic [4:0] reg_idx_t;
    typedef logic [2:0] sb_cnt_t;
endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/writeback side bundle between the pipeline and the hazard scoreboard.
// The master is the pipeline control; the slave is the scoreboard.
interface hazard_scoreboard_if #(
    parameter int CNT_W = 16
);
    import hazard_pkg::*;

    logic              instr_valid;
    logic [31:0]       instr;
    logic              use_rs1;
    logic              use_rs2;
    logic              rd_write;
    logic              flush;
    logic              write_wb;
    reg_idx_t          writeregsel_wb;
    logic              sb_clear;
    logic              stall;
    logic              issue;
    logic              id_bubble;
    logic [31:0]       busy_vec;
    logic [CNT_W-1:0]  stall_cnt;
    logic              sb_err;

    modport master (
        output instr_valid, instr, use_rs1, use_rs2, rd_write, flush,
               write_wb, writeregsel_wb, sb_clear,
        input  stall, issue, id_bubble, busy_vec, stall_cnt, sb_err
    );

    modport slave (
        input  instr_valid, instr, use_rs1, use_rs2, rd_write, flush,
               write_wb, writeregsel_wb, sb_clear,
        output stall, issue, id_bubble, busy_vec, stall_cnt, sb_err
    );
endinterface

// File: rtl/hazard_scoreboard_sb_entry.sv
// One scoreboard slot: counts down the cycles until a pending register
// write becomes readable in decode. Nonzero count means the register is busy.
module sb_entry
    import hazard_pkg::*;
#(
    parameter int WB_LAT = 3
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    clear,
    input  logic    load,
    output logic    busy,
    output sb_cnt_t cnt
);
    sb_cnt_t cnt_reg;

    // Clear beats reload; reload beats decrement so back-to-back writers restart the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= sb_cnt_t'(WB_LAT);
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign cnt  = cnt_reg;
    assign busy = (cnt_reg != '0);
endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW hazard control: per-register in-flight counters, stall /
// issue / bubble generation, saturating stall counter and a sticky flag for
// writebacks that do not line up with the scoreboard.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int WB_LAT  = 3,
    parameter int R0_ZERO = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_scoreboard_if.slave sb
);
    reg_idx_t         rs1;
    reg_idx_t         rs2;
    reg_idx_t         rd;
    reg_idx_t         wb_sel;
    sb_cnt_t          cnt [32];
    logic [31:0]      busy_raw;
    logic [31:0]      busy;
    logic [31:0]      load;
    logic             hazard;
    logic             issue;
    logic             stall;
    logic             wb_mismatch;
    logic             sb_err_reg;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic             unused_instr_bits;

    assign rs1    = sb.instr[RS1_MSB:RS1_LSB];
    assign rs2    = sb.instr[RS2_MSB:RS2_LSB];
    assign rd     = sb.instr[RD_MSB:RD_LSB];
    assign wb_sel = sb.writeregsel_wb;

    // Opcode/funct bits are irrelevant to hazard detection.
    assign unused_instr_bits = ^{sb.instr[31:25], sb.instr[9:0]};

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_entry
            localparam bit HARD_ZERO = (gi == 0) && (R0_ZERO != 0);

            assign load[gi] = issue & sb.rd_write & (rd == reg_idx_t'(gi)) & ~HARD_ZERO;
            assign busy[gi] = busy_raw[gi] & ~HARD_ZERO;

            sb_entry #(
                .WB_LAT (WB_LAT)
            ) u_entry (
                .clk   (clk),
                .rst_n (rst_n),
                .clear (sb.sb_clear),
                .load  (load[gi]),
                .busy  (busy_raw[gi]),
                .cnt   (cnt[gi])
            );
        end
    endgenerate

    // Hazard checks only pre-update state, so an instruction never waits on its own rd.
    assign hazard = sb.instr_valid & ((sb.use_rs1 & busy[rs1]) | (sb.use_rs2 & busy[rs2]));
    assign stall  = hazard & ~sb.flush;
    assign issue  = sb.instr_valid & ~hazard & ~sb.flush;

    // A writeback is legitimate only in the last cycle of its register's window.
    assign wb_mismatch = sb.write_wb & ~sb.sb_clear & (cnt[wb_sel] != sb_cnt_t'(1))
                       & ~((R0_ZERO != 0) && (wb_sel == '0));

    // Sticky error: only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_err_reg <= 1'b0;
        end else if (wb_mismatch) begin
            sb_err_reg <= 1'b1;
        end
    end

    // Saturating stall-cycle counter, deliberately untouched by sb_clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (stall && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign sb.stall     = stall;
    assign sb.issue     = issue;
    assign sb.id_bubble = ~issue;
    assign sb.busy_vec  = busy;
    assign sb.stall_cnt = stall_cnt_reg;
    assign sb.sb_err    = sb_err_reg;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios then random traffic, all
// checked against a model that tracks, per register, the cycle at which its
// pending value becomes readable.
module tb_hazard_scoreboard;
    localparam int WB_LAT = 3;
    localparam int CNT_W  = 4;
    localparam int SAT    = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;

    hazard_scoreboard_if #(.CNT_W(CNT_W)) sb_if ();

    hazard_scoreboard #(
        .WB_LAT  (WB_LAT),
        .R0_ZERO (1),
        .CNT_W   (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb_if)
    );

    int checks = 0;
    int errors = 0;

    // Model state: cycle number, per-register ready cycle, stall count, error flag.
    int cyc = 0;
    int ready_at [32];
    int m_stall_cnt = 0;
    bit m_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int remaining(input int r);
        return (ready_at[r] > cyc) ? ready_at[r] - cyc : 0;
    endfunction

    function automatic bit m_busy(input int r);
        return (r != 0) && (ready_at[r] > cyc);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) ready_at[i] = 0;
        m_stall_cnt = 0;
        m_err = 0;
    endtask

    // Called at a negedge: async reset, immediate check, release a cycle later.
    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_busy_vec", sb_if.busy_vec, 32'h0);
        check("rst_stall", {31'h0, sb_if.stall}, 32'h0);
        check("rst_stall_cnt", {{(32-CNT_W){1'b0}}, sb_if.stall_cnt}, 32'h0);
        check("rst_sb_err", {31'h0, sb_if.sb_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle: drive at negedge, check combinational and registered outputs,
    // then advance the model across the rising edge.
    task automatic step(input bit v, input int r1, input int r2, input int rdx,
                        input bit u1, input bit u2, input bit rw, input bit fl,
                        input bit wb, input int wsel, input bit clr);
        logic [31:0] ins;
        logic [31:0] exp_busy;
        bit hz, exp_stall, exp_issue;
        ins = $urandom;
        ins[19:15] = r1[4:0];
        ins[14:10] = r2[4:0];
        ins[24:20] = rdx[4:0];
        sb_if.instr_valid    = v;
        sb_if.instr          = ins;
        sb_if.use_rs1        = u1;
        sb_if.use_rs2        = u2;
        sb_if.rd_write       = rw;
        sb_if.flush          = fl;
        sb_if.write_wb       = wb;
        sb_if.writeregsel_wb = wsel[4:0];
        sb_if.sb_clear       = clr;
        #1;
        for (int i = 0; i < 32; i++) exp_busy[i] = m_busy(i);
        hz        = v && ((u1 && m_busy(r1)) || (u2 && m_busy(r2)));
        exp_stall = hz && !fl;
        exp_issue = v && !hz && !fl;
        check("busy_vec", sb_if.busy_vec, exp_busy);
        check("stall", {31'h0, sb_if.stall}, {31'h0, exp_stall});
        check("issue", {31'h0, sb_if.issue}, {31'h0, exp_issue});
        check("id_bubble", {31'h0, sb_if.id_bubble}, {31'h0, !exp_issue});
        check("stall_cnt", {{(32-CNT_W){1'b0}}, sb_if.stall_cnt}, m_stall_cnt);
        check("sb_err", {31'h0, sb_if.sb_err}, {31'h0, m_err});
        // Next-state of the model, evaluated on pre-edge values.
        if (wb && !clr && wsel != 0 && remaining(wsel) != 1) m_err = 1;
        if (exp_stall && m_stall_cnt < SAT) m_stall_cnt++;
        @(posedge clk);
        if (clr) begin
            for (int i = 0; i < 32; i++) ready_at[i] = 0;
        end else if (exp_issue && rw && rdx != 0) begin
            ready_at[rdx] = cyc + 1 + WB_LAT;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic writer(input int r);
        step(1, 0, 0, r, 0, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic reader1(input int r);
        step(1, r, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int rsel;
        int cand [$];
        rst_n = 1'b0;
        sb_if.instr_valid = 0; sb_if.instr = '0; sb_if.use_rs1 = 0; sb_if.use_rs2 = 0;
        sb_if.rd_write = 0; sb_if.flush = 0; sb_if.write_wb = 0;
        sb_if.writeregsel_wb = '0; sb_if.sb_clear = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // RAW on r5: three stall cycles, then the reader issues.
        writer(5);
        for (int k = 0; k < 3; k++) reader1(5);
        reader1(5);
        check("raw_stall_cnt", {{(32-CNT_W){1'b0}}, sb_if.stall_cnt}, 32'd3);

        // Flushed writer of r7 never marks it busy.
        step(1, 0, 0, 7, 0, 0, 1, 1, 0, 0, 0);
        check("flush_busy7", {31'h0, sb_if.busy_vec[7]}, 32'h0);
        reader1(7);

        // WAW on r3: only the younger writer's writeback is on time.
        writer(3);
        writer(3);
        idle();
        idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        idle();
        check("waw_no_err", {31'h0, sb_if.sb_err}, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        check("spurious_err", {31'h0, sb_if.sb_err}, 32'h1);
        idle();
        idle();

        // Mid-stream reset with live counters.
        writer(12);
        writer(13);
        do_reset();

        // r0 is never busy.
        writer(0);
        step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        check("r0_busy_vec", sb_if.busy_vec, 32'h0);

        // Repeated RAW stalls push the stall counter into saturation.
        for (int k = 0; k < 7; k++) begin
            writer(6);
            for (int j = 0; j < 4; j++) reader1(6);
        end
        check("sat_stall_cnt", {{(32-CNT_W){1'b0}}, sb_if.stall_cnt}, SAT);

        // Random traffic over a small register window to provoke hazards.
        for (int n = 0; n < 2500; n++) begin
            bit wb;
            if ($urandom_range(0, 299) == 0) do_reset();
            cand.delete();
            for (int i = 1; i < 32; i++) if (remaining(i) == 1) cand.push_back(i);
            wb = 0;
            rsel = 0;
            if (cand.size() != 0 && $urandom_range(0, 3) != 0) begin
                wb = 1;
                rsel = cand[$urandom_range(0, cand.size() - 1)];
            end else if ($urandom_range(0, 39) == 0) begin
                wb = 1;
                rsel = $urandom_range(0, 31);
            end
            step($urandom_range(0, 7) != 0,
                 $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 9) == 0, wb, rsel, $urandom_range(0, 49) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
